writeback_stage: RTL and testbench

- Final pipeline stage; consumes the registered outputs of memory_stage plus the data-memory read response (rdata/rvalid).
- Extracts, aligns and sign/zero-extends load data; selects the rd write source; drives the register-file write port.
- Holds the pipeline until load data arrives; a one-entry buffer absorbs an early rvalid.
- Reports retirement and protocol errors.

---
 rtl/writeback_stage.sv | 160 ++++++++++++++++
 tb/tb_writeback_stage.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. It aligns and extends load data,
// selects the rd write source and drives the register-file write port. It
// stalls upstream until load data arrives, and a one-entry buffer absorbs an
// early read response.
// Optional build macro: LUCID64_RETIRE_CNT_EN adds a 64-bit retired-instruction
// counter on instret_o. When the macro is undefined, instret_o is tied to 0.
module writeback_stage #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rd_data_i,
    input  logic [4:0]      rd_idx_i,
    input  logic            rd_wr_en_i,
    input  logic [2:0]      rd_wr_src_1h_i,
    input  logic [3:0]      mem_width_1h_i,
    input  logic            mem_sign_i,
    input  logic [2:0]      byte_addr_i,
    input  logic [XLEN-1:0] csr_rdata_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_rvalid_i,
    output logic            stall_o,
    output logic            rf_wr_en_o,
    output logic [4:0]      rf_wr_idx_o,
    output logic [XLEN-1:0] rf_wr_data_o,
    output logic            retire_o,
    output logic            rvalid_err_o,
    output logic [63:0]     instret_o
);

    localparam int unsigned CNT_W = 64;

    // IDLE: nothing pending; WAIT: load waiting for rdata; FULL: early rdata buffered
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            err_q, err_d;

    logic            is_load;
    logic            stall_c;
    logic [XLEN-1:0] load_src;
    logic [XLEN-1:0] load_shift;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wr_mux;
    logic            complete;
    logic            wr_en;

    assign is_load = valid_i & rd_wr_src_1h_i[1];

    // State, response buffer and sticky protocol-error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // Next state, stall and load-data source selection
    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        err_d    = err_q;
        stall_c  = 1'b0;
        load_src = dmem_rdata_i;
        case (state_q)
            ST_IDLE: begin
                if (is_load && !dmem_rvalid_i) begin
                    stall_c = 1'b1;
                    state_d = ST_WAIT;
                end else if (!is_load && dmem_rvalid_i) begin
                    buf_d   = dmem_rdata_i;
                    state_d = ST_FULL;
                end
            end
            ST_WAIT: begin
                if (dmem_rvalid_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_c = 1'b1;
                end
            end
            ST_FULL: begin
                load_src = buf_q;
                // A response arriving while one is already buffered has no owner
                if (dmem_rvalid_i) begin
                    err_d = 1'b1;
                end
                if (is_load) begin
                    buf_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign load_shift = load_src >> {byte_addr_i, 3'b000};

    // Width extraction with sign or zero extension
    always_comb begin
        load_data = '0;
        case (mem_width_1h_i)
            4'b0001: load_data = {{(XLEN-8){mem_sign_i & load_shift[7]}}, load_shift[7:0]};
            4'b0010: load_data = {{(XLEN-16){mem_sign_i & load_shift[15]}}, load_shift[15:0]};
            4'b0100: load_data = {{(XLEN-32){mem_sign_i & load_shift[31]}}, load_shift[31:0]};
            4'b1000: load_data = load_shift;
            default: load_data = '0;
        endcase
    end

    // One-hot rd write source select
    always_comb begin
        wr_mux = '0;
        case (rd_wr_src_1h_i)
            3'b001:  wr_mux = rd_data_i;
            3'b010:  wr_mux = load_data;
            3'b100:  wr_mux = csr_rdata_i;
            default: wr_mux = '0;
        endcase
    end

    // Outputs are gated by rst_ni so they drop immediately when reset is asserted
    assign complete     = rst_ni & valid_i & ~stall_c;
    assign wr_en        = complete & rd_wr_en_i & (rd_idx_i != 5'd0);
    assign stall_o      = rst_ni & stall_c;
    assign retire_o     = complete;
    assign rf_wr_en_o   = wr_en;
    assign rf_wr_idx_o  = wr_en ? rd_idx_i : 5'd0;
    assign rf_wr_data_o = wr_en ? wr_mux : '0;
    assign rvalid_err_o = err_q;

`ifdef LUCID64_RETIRE_CNT_EN
    logic [CNT_W-1:0] instret_q;

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q <= '0;
        end else if (complete) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_writeback_stage;

`ifdef LUCID64_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic [63:0] rd_data_i;
    logic [4:0]  rd_idx_i;
    logic        rd_wr_en_i;
    logic [2:0]  rd_wr_src_1h_i;
    logic [3:0]  mem_width_1h_i;
    logic        mem_sign_i;
    logic [2:0]  byte_addr_i;
    logic [63:0] csr_rdata_i;
    logic [63:0] dmem_rdata_i;
    logic        dmem_rvalid_i;
    logic        stall_o;
    logic        rf_wr_en_o;
    logic [4:0]  rf_wr_idx_o;
    logic [63:0] rf_wr_data_o;
    logic        retire_o;
    logic        rvalid_err_o;
    logic [63:0] instret_o;

    int total = 0;
    int bad   = 0;

    writeback_stage #(.XLEN(64)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .rd_data_i      (rd_data_i),
        .rd_idx_i       (rd_idx_i),
        .rd_wr_en_i     (rd_wr_en_i),
        .rd_wr_src_1h_i (rd_wr_src_1h_i),
        .mem_width_1h_i (mem_width_1h_i),
        .mem_sign_i     (mem_sign_i),
        .byte_addr_i    (byte_addr_i),
        .csr_rdata_i    (csr_rdata_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .stall_o        (stall_o),
        .rf_wr_en_o     (rf_wr_en_o),
        .rf_wr_idx_o    (rf_wr_idx_o),
        .rf_wr_data_o   (rf_wr_data_o),
        .retire_o       (retire_o),
        .rvalid_err_o   (rvalid_err_o),
        .instret_o      (instret_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        valid;
        logic [63:0] rd_data;
        logic [4:0]  idx;
        logic        wr_en;
        logic [2:0]  src;
        logic [3:0]  width;
        logic        sign;
        logic [2:0]  addr;
        logic [63:0] csr;
        logic [63:0] rdata;
        logic        rvalid;
        logic        exp_en;
        logic [4:0]  exp_idx;
        logic [63:0] exp_data;
        logic        exp_retire;
        logic        exp_stall;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic v, input logic [63:0] rdd, input logic [4:0] idx,
                       input logic we, input logic [2:0] src, input logic [3:0] w,
                       input logic sg, input logic [2:0] ad, input logic [63:0] csr,
                       input logic [63:0] rd, input logic rv);
        valid_i        = v;
        rd_data_i      = rdd;
        rd_idx_i       = idx;
        rd_wr_en_i     = we;
        rd_wr_src_1h_i = src;
        mem_width_1h_i = w;
        mem_sign_i     = sg;
        byte_addr_i    = ad;
        csr_rdata_i    = csr;
        dmem_rdata_i   = rd;
        dmem_rvalid_i  = rv;
    endtask

    task automatic idle_in();
        drv(1'b0, 64'd0, 5'd0, 1'b0, 3'b000, 4'b0000, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        idle_in();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    // Reference load extraction by plain arithmetic
    function automatic logic [63:0] ref_load(input logic [63:0] rd, input logic [2:0] ad,
                                             input logic [3:0] w, input logic sg);
        logic [63:0] sh;
        logic [63:0] v;
        int nbits;
        sh = rd >> (8 * int'(ad));
        case (w)
            4'b0001: nbits = 8;
            4'b0010: nbits = 16;
            4'b0100: nbits = 32;
            4'b1000: nbits = 64;
            default: nbits = 0;
        endcase
        if (nbits == 0) return 64'd0;
        if (nbits == 64) return sh;
        v = sh & ((64'd1 << nbits) - 64'd1);
        if (sg && v[nbits-1]) v = v - (64'd1 << nbits);
        return v;
    endfunction

    function automatic logic [63:0] ref_mux(input logic [2:0] src, input logic [63:0] alu,
                                            input logic [63:0] ld, input logic [63:0] csr);
        if (src == 3'b001) return alu;
        if (src == 3'b010) return ld;
        if (src == 3'b100) return csr;
        return 64'd0;
    endfunction

    vec_t vecs [10];

    // Model state for randomized traffic
    logic [63:0] pend_q [$];
    bit          m_wait;
    bit          m_err;
    longint unsigned m_cnt;

    initial begin
        logic [63:0] ld;
        logic        m_stall;
        logic        m_comp;
        logic        m_en;
        logic        m_isld;
        logic [2:0]  srcs [4];

        rst_ni = 1'b0;
        idle_in();

        vecs[0] = '{1'b1, 64'h1234, 5'd5, 1'b1, 3'b001, 4'b0000, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0,
                    1'b1, 5'd5, 64'h1234, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 64'h7777, 5'd10, 1'b1, 3'b100, 4'b0000, 1'b0, 3'd0, 64'hABCD, 64'd0, 1'b0,
                    1'b1, 5'd10, 64'hABCD, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 64'd0, 5'd7, 1'b1, 3'b010, 4'b0100, 1'b1, 3'd4, 64'd0, 64'h8000_0000_0000_0000, 1'b1,
                    1'b1, 5'd7, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 64'd0, 5'd8, 1'b1, 3'b010, 4'b0010, 1'b0, 3'd2, 64'd0, 64'h0000_0000_BEEF_0000, 1'b1,
                    1'b1, 5'd8, 64'h0000_0000_0000_BEEF, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 64'd0, 5'd9, 1'b1, 3'b010, 4'b1000, 1'b1, 3'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b1,
                    1'b1, 5'd9, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 64'd0, 5'd0, 1'b1, 3'b010, 4'b0001, 1'b0, 3'd0, 64'd0, 64'h55, 1'b1,
                    1'b0, 5'd0, 64'd0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 64'h99, 5'd4, 1'b0, 3'b001, 4'b0000, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0,
                    1'b0, 5'd0, 64'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 64'h99, 5'd3, 1'b1, 3'b011, 4'b1000, 1'b0, 3'd0, 64'd0, 64'h42, 1'b1,
                    1'b1, 5'd3, 64'd0, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 64'd0, 5'd6, 1'b1, 3'b010, 4'b0011, 1'b1, 3'd0, 64'd0, 64'hFFFF, 1'b1,
                    1'b1, 5'd6, 64'd0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 64'h5, 5'd5, 1'b1, 3'b001, 4'b0000, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0,
                    1'b0, 5'd0, 64'd0, 1'b0, 1'b0};

        // Reset state
        #2;
        chk("rst_stall", 64'(stall_o), 64'd0);
        chk("rst_retire", 64'(retire_o), 64'd0);
        chk("rst_en", 64'(rf_wr_en_o), 64'd0);
        chk("rst_err", 64'(rvalid_err_o), 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single-cycle vectors from IDLE
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            drv(vecs[i].valid, vecs[i].rd_data, vecs[i].idx, vecs[i].wr_en, vecs[i].src,
                vecs[i].width, vecs[i].sign, vecs[i].addr, vecs[i].csr, vecs[i].rdata, vecs[i].rvalid);
            #1;
            chk($sformatf("vec%0d_en", i), 64'(rf_wr_en_o), 64'(vecs[i].exp_en));
            chk($sformatf("vec%0d_idx", i), 64'(rf_wr_idx_o), 64'(vecs[i].exp_idx));
            chk($sformatf("vec%0d_data", i), rf_wr_data_o, vecs[i].exp_data);
            chk($sformatf("vec%0d_retire", i), 64'(retire_o), 64'(vecs[i].exp_retire));
            chk($sformatf("vec%0d_stall", i), 64'(stall_o), 64'(vecs[i].exp_stall));
        end

        // Byte load at offset 3, response two cycles late, signed then unsigned
        for (int s = 1; s >= 0; s--) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk_i);
                drv(1'b1, 64'd0, 5'd11, 1'b1, 3'b010, 4'b0001, 1'(s), 3'd3, 64'd0,
                    64'h0000_0000_8000_0000, 1'(c == 2));
                #1;
                chk($sformatf("lat_s%0d_c%0d_stall", s, c), 64'(stall_o), 64'(c != 2));
                chk($sformatf("lat_s%0d_c%0d_retire", s, c), 64'(retire_o), 64'(c == 2));
            end
            chk($sformatf("lat_s%0d_data", s), rf_wr_data_o,
                (s == 1) ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h0000_0000_0000_0080);
        end

        // Early response buffered, consumed by the next load without a stall
        @(negedge clk_i);
        drv(1'b0, 64'd0, 5'd0, 1'b0, 3'b000, 4'b0000, 1'b0, 3'd0, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        #1;
        chk("early_stall", 64'(stall_o), 64'd0);
        chk("early_retire", 64'(retire_o), 64'd0);
        @(negedge clk_i);
        drv(1'b1, 64'd0, 5'd12, 1'b1, 3'b010, 4'b0100, 1'b0, 3'd4, 64'd0, 64'd0, 1'b0);
        #1;
        chk("buf_stall", 64'(stall_o), 64'd0);
        chk("buf_data", rf_wr_data_o, 64'h0000_0000_DEAD_BEEF);
        chk("buf_en", 64'(rf_wr_en_o), 64'd1);
        // Back in IDLE: a load without rvalid must stall again
        @(negedge clk_i);
        drv(1'b1, 64'd0, 5'd13, 1'b1, 3'b010, 4'b1000, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        #1;
        chk("idle_again_stall", 64'(stall_o), 64'd1);
        @(negedge clk_i);
        drv(1'b1, 64'd0, 5'd13, 1'b1, 3'b010, 4'b1000, 1'b0, 3'd0, 64'd0, 64'h55, 1'b1);
        #1;
        chk("idle_again_data", rf_wr_data_o, 64'h55);
        chk("pre_err", 64'(rvalid_err_o), 64'd0);

        // Second response while buffer full: error, old contents kept
        @(negedge clk_i);
        drv(1'b0, 64'd0, 5'd0, 1'b0, 3'b000, 4'b0000, 1'b0, 3'd0, 64'd0, 64'h1111_2222_3333_4444, 1'b1);
        @(negedge clk_i);
        drv(1'b0, 64'd0, 5'd0, 1'b0, 3'b000, 4'b0000, 1'b0, 3'd0, 64'd0, 64'h9999, 1'b1);
        #1;
        chk("full_err_before", 64'(rvalid_err_o), 64'd0);
        @(negedge clk_i);
        drv(1'b1, 64'd0, 5'd14, 1'b1, 3'b010, 4'b1000, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        #1;
        chk("full_err_set", 64'(rvalid_err_o), 64'd1);
        chk("full_keep_data", rf_wr_data_o, 64'h1111_2222_3333_4444);
        chk("full_keep_stall", 64'(stall_o), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            idle_in();
            #1;
            chk($sformatf("err_sticky%0d", c), 64'(rvalid_err_o), 64'd1);
        end

        // Reset asserted mid-WAIT drops all outputs without a clock edge
        @(negedge clk_i);
        drv(1'b1, 64'h3, 5'd15, 1'b1, 3'b010, 4'b0001, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
        @(negedge clk_i);
        #1;
        chk("wait_stall", 64'(stall_o), 64'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_stall", 64'(stall_o), 64'd0);
        chk("arst_retire", 64'(retire_o), 64'd0);
        chk("arst_en", 64'(rf_wr_en_o), 64'd0);
        chk("arst_data", rf_wr_data_o, 64'd0);
        chk("arst_err", 64'(rvalid_err_o), 64'd0);
        chk("arst_instret", instret_o, 64'd0);
        @(negedge clk_i);
        idle_in();
        rst_ni = 1'b1;

        // Ten ALU ops then one load stalled for three cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            drv(1'b1, 64'(i), 5'd1, 1'b1, 3'b001, 4'b0000, 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
            #1;
            chk($sformatf("alu%0d_retire", i), 64'(retire_o), 64'd1);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            drv(1'b1, 64'd0, 5'd2, 1'b1, 3'b010, 4'b1000, 1'b0, 3'd0, 64'd0, 64'h77, 1'(c == 3));
            #1;
            chk($sformatf("ld3_c%0d_stall", c), 64'(stall_o), 64'(c != 3));
        end
        @(negedge clk_i);
        idle_in();
        #1;
        chk("instret_11", instret_o, CNT_EN ? 64'd11 : 64'd0);

        // Randomized traffic against the behavioural model
        do_reset();
        pend_q.delete();
        m_wait = 0;
        m_err  = 0;
        m_cnt  = 0;
        srcs[0] = 3'b001; srcs[1] = 3'b010; srcs[2] = 3'b100; srcs[3] = 3'b000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_i);
            if (!m_wait) begin
                valid_i        = ($urandom_range(0, 3) != 0);
                rd_data_i      = {$urandom, $urandom};
                rd_idx_i       = 5'($urandom_range(0, 31));
                rd_wr_en_i     = ($urandom_range(0, 4) != 0);
                rd_wr_src_1h_i = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                             : srcs[$urandom_range(0, 2)];
                mem_width_1h_i = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                             : 4'(1 << $urandom_range(0, 3));
                mem_sign_i     = 1'($urandom_range(0, 1));
                byte_addr_i    = 3'($urandom_range(0, 7));
                csr_rdata_i    = {$urandom, $urandom};
            end
            dmem_rdata_i  = {$urandom, $urandom};
            dmem_rvalid_i = ($urandom_range(0, 2) == 0);

            m_isld = valid_i & rd_wr_src_1h_i[1];
            if (m_wait) begin
                m_stall = !dmem_rvalid_i;
                ld = ref_load(dmem_rdata_i, byte_addr_i, mem_width_1h_i, mem_sign_i);
            end else if (pend_q.size() != 0) begin
                m_stall = 1'b0;
                ld = ref_load(pend_q[0], byte_addr_i, mem_width_1h_i, mem_sign_i);
            end else begin
                m_stall = m_isld & !dmem_rvalid_i;
                ld = ref_load(dmem_rdata_i, byte_addr_i, mem_width_1h_i, mem_sign_i);
            end
            m_comp = valid_i & !m_stall;
            m_en   = m_comp & rd_wr_en_i & (rd_idx_i != 5'd0);

            #1;
            chk("rnd_stall", 64'(stall_o), 64'(m_stall));
            chk("rnd_retire", 64'(retire_o), 64'(m_comp));
            chk("rnd_en", 64'(rf_wr_en_o), 64'(m_en));
            chk("rnd_idx", 64'(rf_wr_idx_o), m_en ? 64'(rd_idx_i) : 64'd0);
            chk("rnd_data", rf_wr_data_o,
                m_en ? ref_mux(rd_wr_src_1h_i, rd_data_i, ld, csr_rdata_i) : 64'd0);
            chk("rnd_err", 64'(rvalid_err_o), 64'(m_err));
            chk("rnd_instret", instret_o, CNT_EN ? 64'(m_cnt) : 64'd0);

            if (m_comp) m_cnt++;
            if (m_wait) begin
                if (dmem_rvalid_i) m_wait = 0;
            end else if (pend_q.size() != 0) begin
                if (dmem_rvalid_i) m_err = 1;
                if (m_isld) void'(pend_q.pop_front());
            end else begin
                if (m_isld && !dmem_rvalid_i) m_wait = 1;
                if (!m_isld && dmem_rvalid_i) pend_q.push_back(dmem_rdata_i);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
